// File: rtl/wb_ram_bsel_if.sv
// Classic-pipelined Wishbone bus bundle for the byte-select RAM slave.
interface wb_ram_bsel_if #(
    parameter int WIDTH     = 16,
    parameter int ADR_WIDTH = 16
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [ADR_WIDTH-1:0]   adr;
    logic [WIDTH/8-1:0]     sel;
    logic [WIDTH-1:0]       dat_i;
    logic [WIDTH-1:0]       dat_o;
    logic                   ack;
    logic                   err;
    logic                   stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_i,
        input  dat_o, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, err, stall
    );
endinterface

// File: rtl/wb_ram_bsel.sv
// Single-port synchronous RAM slave on a classic-pipelined Wishbone bus.
// Byte-lane writes, optional per-access wait states (aborted by cyc low),
// and an error termination for words beyond the configured depth.
module wb_ram_bsel #(
    parameter int size       = 'h800,
    parameter int width      = 16,
    parameter int adr_width  = 16,
    parameter int waitcycles = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_ram_bsel_if.slave    bus
);
    localparam int LANES = width / 8;
    localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
    // Depth widened by one bit so the range compare never truncates.
    localparam logic [adr_width:0] SIZE_L = (adr_width + 1)'(size);

    logic               w_valid;
    logic               w_accept;
    logic               w_inrange;
    logic               w_stall;
    logic               w_wr;
    logic               w_rd;
    logic [IDX_W-1:0]   w_idx;
    logic [width-1:0]   w_rd_data;

    logic               r_ack;
    logic               r_err;
    // Set while dat_o must read as zero (after reset or an out-of-range read).
    logic               r_zero;

    assign w_valid   = bus.cyc & bus.stb;
    assign w_inrange = ({1'b0, bus.adr} < SIZE_L);
    assign w_accept  = w_valid & ~w_stall;
    // Upper address bits only matter for the range compare.
    assign w_idx     = bus.adr[IDX_W-1:0];
    assign w_wr      = w_accept &  bus.we & w_inrange;
    assign w_rd      = w_accept & ~bus.we & w_inrange;

    genvar gi;
    generate
        if (waitcycles == 0) begin : g_nowait
            assign w_stall = 1'b0;
        end else begin : g_wait
            localparam logic [3:0] WAIT_N = 4'(waitcycles);
            logic [3:0] r_cnt;

            // Count down stall cycles while valid; reload on accept or when the master abandons the cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= WAIT_N;
                end else if (!bus.cyc) begin
                    r_cnt <= WAIT_N;
                end else if (w_valid) begin
                    r_cnt <= (r_cnt != 4'd0) ? r_cnt - 4'd1 : WAIT_N;
                end
            end

            assign w_stall = w_valid & (r_cnt != 4'd0);
        end

        // One 8-bit RAM per byte lane so each lane has its own write enable.
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] r_mem [size];
            logic [7:0] r_rd;

            // Lane write at the accept edge; registered read holds until the next in-range read.
            always_ff @(posedge clk) begin
                if (w_wr && bus.sel[gi]) begin
                    r_mem[w_idx] <= bus.dat_i[8*gi +: 8];
                end
                if (w_rd) begin
                    r_rd <= r_mem[w_idx];
                end
            end

            assign w_rd_data[8*gi +: 8] = r_rd;
        end
    endgenerate

    // Terminate every accepted access one cycle later; track when read data must show zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_ack <= w_accept &  w_inrange;
            r_err <= w_accept & ~w_inrange;
            if (w_rd) begin
                r_zero <= 1'b0;
            end else if (w_accept && !bus.we && !w_inrange) begin
                r_zero <= 1'b1;
            end
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.stall = w_stall;
    assign bus.dat_o = r_zero ? '0 : w_rd_data;
endmodule

// File: tb/tb_wb_ram_bsel.sv
// Scoreboard bench for wb_ram_bsel: three instances (0, 2 and 3 wait states),
// one driven at a time through a shared stimulus set.
module tb_wb_ram_bsel;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        t_cyc, t_stb, t_we;
    logic [15:0] t_adr;
    logic [3:0]  t_sel;
    logic [31:0] t_dat;
    int          act;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          dut;
        int          cycle;
        bit          is_err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    wb_ram_bsel_if #(.WIDTH(32), .ADR_WIDTH(16)) b_w0 ();
    wb_ram_bsel_if #(.WIDTH(32), .ADR_WIDTH(16)) b_w2 ();
    wb_ram_bsel_if #(.WIDTH(32), .ADR_WIDTH(16)) b_w3 ();

    assign b_w0.cyc = t_cyc & (act == 0);
    assign b_w2.cyc = t_cyc & (act == 1);
    assign b_w3.cyc = t_cyc & (act == 2);
    assign b_w0.stb = t_stb;  assign b_w2.stb = t_stb;  assign b_w3.stb = t_stb;
    assign b_w0.we  = t_we;   assign b_w2.we  = t_we;   assign b_w3.we  = t_we;
    assign b_w0.adr = t_adr;  assign b_w2.adr = t_adr;  assign b_w3.adr = t_adr;
    assign b_w0.sel = t_sel;  assign b_w2.sel = t_sel;  assign b_w3.sel = t_sel;
    assign b_w0.dat_i = t_dat; assign b_w2.dat_i = t_dat; assign b_w3.dat_i = t_dat;

    wb_ram_bsel #(.size('h600), .width(32), .adr_width(16), .waitcycles(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .bus(b_w0.slave));
    wb_ram_bsel #(.size('h800), .width(32), .adr_width(16), .waitcycles(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .bus(b_w2.slave));
    wb_ram_bsel #(.size('h800), .width(32), .adr_width(16), .waitcycles(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .bus(b_w3.slave));

    logic        m_ack[3], m_err[3], m_stall[3];
    logic [31:0] m_dat[3];
    assign m_ack[0] = b_w0.ack;   assign m_ack[1] = b_w2.ack;   assign m_ack[2] = b_w3.ack;
    assign m_err[0] = b_w0.err;   assign m_err[1] = b_w2.err;   assign m_err[2] = b_w3.err;
    assign m_stall[0] = b_w0.stall; assign m_stall[1] = b_w2.stall; assign m_stall[2] = b_w3.stall;
    assign m_dat[0] = b_w0.dat_o; assign m_dat[1] = b_w2.dat_o; assign m_dat[2] = b_w3.dat_o;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_cnt, act_v, req_v);
        end
    endtask

    // One access: check stall each cycle, queue the expected response on the accepting cycle.
    task automatic xfer(input int k, input bit w, input logic [15:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int nstall, input bit exp_err,
                        input bit chk, input logic [31:0] exp_dat);
        act = k; t_cyc = 1'b1; t_stb = 1'b1; t_we = w; t_adr = a; t_sel = s; t_dat = d;
        for (int i = 0; i <= nstall; i++) begin
            #1;
            check("stall", {31'b0, m_stall[k]}, {31'b0, (i < nstall)});
            if (i == nstall)
                sb.push_back('{dut: k, cycle: cyc_cnt + 1, is_err: exp_err, chk: chk, dat: exp_dat});
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pop and compare whenever any instance terminates; flag late or missing responses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (m_ack[k] || m_err[k]) begin
                    checks++;
                    $display("resp dut=%0d cycle=%0d ack=%b err=%b dat=%h", k, cyc_cnt, m_ack[k], m_err[k], m_dat[k]);
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp dut=%0d cycle=%0d ack=%b err=%b required none",
                                 k, cyc_cnt, m_ack[k], m_err[k]);
                    end else begin
                        e = sb.pop_front();
                        if (e.dut != k || e.cycle != cyc_cnt || m_ack[k] !== !e.is_err ||
                            m_err[k] !== e.is_err || (e.chk && m_dat[k] !== e.dat)) begin
                            errors++;
                            $display("FAIL resp actual dut=%0d cycle=%0d ack=%b err=%b dat=%h required dut=%0d cycle=%0d ack=%b err=%b dat=%h",
                                     k, cyc_cnt, m_ack[k], m_err[k], m_dat[k],
                                     e.dut, e.cycle, !e.is_err, e.is_err, e.dat);
                        end
                    end
                end
            end
            if (sb.size() > 0 && sb[0].cycle < cyc_cnt) begin
                checks++;
                errors++;
                e = sb.pop_front();
                $display("FAIL missing_resp dut=%0d actual=none required ack/err at cycle %0d",
                         e.dut, e.cycle);
            end
        end
    end

    initial begin
        rst_n = 1'b0; act = 0;
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0; t_adr = '0; t_sel = '0; t_dat = '0;
        #12;
        for (int k = 0; k < 3; k++) begin
            check("rst_ack",   {31'b0, m_ack[k]},   32'd0);
            check("rst_err",   {31'b0, m_err[k]},   32'd0);
            check("rst_stall", {31'b0, m_stall[k]}, 32'd0);
            check("rst_dat",   m_dat[k],            32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No wait states: write then immediate read of the same word.
        xfer(0, 1'b1, 16'd5, 4'hF, 32'hDEADBEEF, 0, 1'b0, 1'b1, 32'h0);
        xfer(0, 1'b0, 16'd5, 4'hF, 32'h0,        0, 1'b0, 1'b1, 32'hDEADBEEF);
        // Byte lanes, including sel=0.
        xfer(0, 1'b1, 16'd3, 4'hF,    32'h11223344, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b1, 16'd3, 4'b0101, 32'hAABBCCDD, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b0, 16'd3, 4'hF,    32'h0,        0, 1'b0, 1'b1, 32'h11BB33DD);
        xfer(0, 1'b1, 16'd3, 4'h0,    32'hFFFFFFFF, 0, 1'b0, 1'b1, 32'h11BB33DD);
        xfer(0, 1'b0, 16'd3, 4'hF,    32'h0,        0, 1'b0, 1'b1, 32'h11BB33DD);
        idle(2);
        // Range boundary on the 'h600-word instance.
        xfer(0, 1'b0, 16'h0600, 4'hF, 32'h0,        0, 1'b1, 1'b1, 32'h0);
        xfer(0, 1'b1, 16'h05FF, 4'hF, 32'hCAFEF00D, 0, 1'b0, 1'b1, 32'h0);
        xfer(0, 1'b0, 16'h05FF, 4'hF, 32'h0,        0, 1'b0, 1'b1, 32'hCAFEF00D);
        xfer(0, 1'b0, 16'hFFFF, 4'hF, 32'h0,        0, 1'b1, 1'b1, 32'h0);
        idle(2);

        // Two wait states, then back-to-back reads.
        xfer(1, 1'b1, 16'd7, 4'hF, 32'h00C0FFEE, 2, 1'b0, 1'b0, 32'h0);
        idle(1);
        xfer(1, 1'b1, 16'd8, 4'hF, 32'h0BADCAFE, 2, 1'b0, 1'b0, 32'h0);
        idle(1);
        xfer(1, 1'b0, 16'd7, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h00C0FFEE);
        xfer(1, 1'b0, 16'd8, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h0BADCAFE);
        // Aliased upper address bits: error, no write to word 7, dat_o held.
        xfer(1, 1'b1, 16'h0807, 4'hF, 32'hFFFFFFFF, 2, 1'b1, 1'b1, 32'h0BADCAFE);
        xfer(1, 1'b0, 16'd7,    4'hF, 32'h0,        2, 1'b0, 1'b1, 32'h00C0FFEE);
        idle(2);

        // Three wait states: abort by dropping cyc, then stb-low hold.
        xfer(2, 1'b1, 16'd2, 4'hF, 32'h13579BDF, 3, 1'b0, 1'b0, 32'h0);
        idle(1);
        act = 2; t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 16'd2;
        for (int i = 0; i < 2; i++) begin
            #1; check("abort_stall", {31'b0, m_stall[2]}, 32'd1);
            @(posedge clk); #1;
        end
        t_cyc = 1'b0; t_stb = 1'b0;
        #1; check("abort_idle_stall", {31'b0, m_stall[2]}, 32'd0);
        @(posedge clk); #1;
        xfer(2, 1'b0, 16'd2, 4'hF, 32'h0, 3, 1'b0, 1'b1, 32'h13579BDF);
        idle(1);
        t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 16'd2;
        #1; check("hold_stall", {31'b0, m_stall[2]}, 32'd1);
        @(posedge clk); #1;
        t_stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1; check("hold_nostb_stall", {31'b0, m_stall[2]}, 32'd0);
            @(posedge clk); #1;
        end
        xfer(2, 1'b0, 16'd2, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'h13579BDF);
        idle(2);

        // Asynchronous reset while an ack is pending; the accepted write survives.
        act = 1; t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 16'd9; t_sel = 4'hF; t_dat = 32'hA5A5A5A5;
        for (int i = 0; i <= 2; i++) begin
            #1; check("pre_rst_stall", {31'b0, m_stall[1]}, {31'b0, (i < 2)});
            @(posedge clk); #1;
        end
        t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0;
        check("pending_ack", {31'b0, m_ack[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'b0, m_ack[1]}, 32'd0);
        check("async_rst_dat", m_dat[1], 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 16'd9, 4'hF, 32'h0, 2, 1'b0, 1'b1, 32'hA5A5A5A5);
        idle(3);

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
